noc_queue_param: RTL and testbench

NOC_QUEUE_PARAM -- requirements
Module: noc_queue_param

---
 rtl/noc_queue_param_if.sv | 31 +++
 rtl/noc_queue_param.sv | 89 ++++++++
 tb/tb_noc_queue_param.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/noc_queue_param_if.sv
// Handshake bundle for noc_queue_param: producer push side, consumer pop side,
// occupancy flags and sticky error indicators.
interface noc_queue_param_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              Flush;
    logic              PushReq;
    logic [DATA_W-1:0] PushData;
    logic              Full;
    logic              AlmostFull;
    logic              PopReq;
    logic [DATA_W-1:0] PopData;
    logic              Empty;
    logic              AlmostEmpty;
    logic [CNT_W-1:0]  Count;
    logic              Overflow;
    logic              Underflow;

    modport master (
        output Flush, PushReq, PushData, PopReq,
        input  Full, AlmostFull, PopData, Empty, AlmostEmpty, Count, Overflow, Underflow
    );

    modport slave (
        input  Flush, PushReq, PushData, PopReq,
        output Full, AlmostFull, PopData, Empty, AlmostEmpty, Count, Overflow, Underflow
    );
endinterface

// File: rtl/noc_queue_param.sv
// Parameterised first-word-fall-through queue with occupancy thresholds,
// synchronous flush and sticky overflow/underflow indicators.
module noc_queue_param #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int AFULL_TH  = DEPTH - 1,
    parameter int AEMPTY_TH = 1
) (
    input logic             CLK,
    input logic             RST,
    noc_queue_param_if.slave q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wp_q, wp_d;
    logic [PTR_W-1:0] rp_q, rp_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic full, empty, push_ok, pop_ok;

    // A push into a full queue is still accepted when a pop frees the head slot at the same edge.
    always_comb begin
        full    = (count_q == CNT_W'(DEPTH));
        empty   = (count_q == '0);
        pop_ok  = q.PopReq && !empty;
        push_ok = q.PushReq && (!full || pop_ok);

        wp_d        = wp_q;
        rp_d        = rp_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (q.Flush) begin
            wp_d        = '0;
            rp_d        = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push_ok) wp_d = wp_q + PTR_W'(1);
            if (pop_ok)  rp_d = rp_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (q.PushReq && !push_ok) overflow_d  = 1'b1;
            if (q.PopReq && empty)     underflow_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wp_q        <= '0;
            rp_q        <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset; stale words are never visible while Empty.
    always_ff @(posedge CLK) begin
        if (!q.Flush && push_ok) begin
            mem_q[wp_q] <= q.PushData;
        end
    end

    assign q.Full        = full;
    assign q.Empty       = empty;
    assign q.AlmostFull  = (count_q >= CNT_W'(AFULL_TH));
    assign q.AlmostEmpty = (count_q <= CNT_W'(AEMPTY_TH));
    assign q.Count       = count_q;
    assign q.Overflow    = overflow_q;
    assign q.Underflow   = underflow_q;
    assign q.PopData     = mem_q[rp_q];
endmodule

// File: tb/tb_noc_queue_param.sv
// Self-checking bench for noc_queue_param: directed vector table, hand-written
// reset/wrap sequences and randomized traffic against a queue-based model.
module tb_noc_queue_param;
    localparam int DATA_W    = 32;
    localparam int DEPTH     = 4;
    localparam int AFULL_TH  = DEPTH - 1;
    localparam int AEMPTY_TH = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    noc_queue_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    noc_queue_param #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .q  (bus)
    );

    always #5 clk = ~clk;

    // ctrl = {flush, push, pop}; flags = {full, afull, empty, aempty, ovf, unf, head_valid}
    typedef struct {
        logic [2:0]  ctrl;
        logic [31:0] data;
        int          cnt;
        logic [6:0]  flags;
        logic [31:0] head;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] mq[$];
    logic [31:0] popped[$];
    bit          m_ovf = 1'b0;
    bit          m_unf = 1'b0;
    int          cmp_count = 0;
    int          fail_count = 0;

    function automatic vec_t mk(logic [2:0] c, logic [31:0] d, int n, logic [6:0] f, logic [31:0] h);
        vec_t v;
        v.ctrl = c; v.data = d; v.cnt = n; v.flags = f; v.head = h;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the following falling edge.
    task automatic apply_stimulus(input bit f, input bit pu, input bit po, input logic [31:0] d);
        bus.Flush    = f;
        bus.PushReq  = pu;
        bus.PopReq   = po;
        bus.PushData = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_idle();
        bus.Flush = 1'b0; bus.PushReq = 1'b0; bus.PopReq = 1'b0; bus.PushData = '0;
    endtask

    task automatic compare_model(input string tag);
        int n;
        n = mq.size();
        check_output({tag, " count"},  32'(bus.Count),       32'(n));
        check_output({tag, " full"},   32'(bus.Full),        32'(n == DEPTH));
        check_output({tag, " empty"},  32'(bus.Empty),       32'(n == 0));
        check_output({tag, " afull"},  32'(bus.AlmostFull),  32'(n >= AFULL_TH));
        check_output({tag, " aempty"}, 32'(bus.AlmostEmpty), 32'(n <= AEMPTY_TH));
        check_output({tag, " ovf"},    32'(bus.Overflow),    32'(m_ovf));
        check_output({tag, " unf"},    32'(bus.Underflow),   32'(m_unf));
        if (n > 0) check_output({tag, " head"}, bus.PopData, mq[0]);
    endtask

    // Model: a plain FIFO of words; pops come off the front, pushes go on the back.
    task automatic model_step(input string tag, input bit f, input bit pu, input bit po, input logic [31:0] d);
        bit pop_ok, push_ok;
        if (!f && po && mq.size() > 0) popped.push_back(bus.PopData);
        apply_stimulus(f, pu, po, d);
        if (f) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            pop_ok  = po && (mq.size() > 0);
            push_ok = pu && ((mq.size() < DEPTH) || pop_ok);
            if (pu && !push_ok)     m_ovf = 1'b1;
            if (po && mq.size() == 0) m_unf = 1'b1;
            if (pop_ok)  void'(mq.pop_front());
            if (push_ok) mq.push_back(d);
        end
        compare_model(tag);
    endtask

    initial begin
        bit          f, pu, po;
        logic [31:0] d;

        vecs.push_back(mk(3'b010, 32'h11, 1, 7'b0001001, 32'h11));
        vecs.push_back(mk(3'b010, 32'h22, 2, 7'b0000001, 32'h11));
        vecs.push_back(mk(3'b010, 32'h33, 3, 7'b0100001, 32'h11));
        vecs.push_back(mk(3'b010, 32'h44, 4, 7'b1100001, 32'h11));
        vecs.push_back(mk(3'b010, 32'h55, 4, 7'b1100101, 32'h11));
        vecs.push_back(mk(3'b001, 32'h00, 3, 7'b0100101, 32'h22));
        vecs.push_back(mk(3'b001, 32'h00, 2, 7'b0000101, 32'h33));
        vecs.push_back(mk(3'b001, 32'h00, 1, 7'b0001101, 32'h44));
        vecs.push_back(mk(3'b001, 32'h00, 0, 7'b0011100, 32'h00));
        vecs.push_back(mk(3'b100, 32'h00, 0, 7'b0011000, 32'h00));
        vecs.push_back(mk(3'b010, 32'h01, 1, 7'b0001001, 32'h01));
        vecs.push_back(mk(3'b010, 32'h02, 2, 7'b0000001, 32'h01));
        vecs.push_back(mk(3'b010, 32'h03, 3, 7'b0100001, 32'h01));
        vecs.push_back(mk(3'b010, 32'h04, 4, 7'b1100001, 32'h01));
        vecs.push_back(mk(3'b011, 32'hA5, 4, 7'b1100001, 32'h02));
        vecs.push_back(mk(3'b001, 32'h00, 3, 7'b0100001, 32'h03));
        vecs.push_back(mk(3'b001, 32'h00, 2, 7'b0000001, 32'h04));
        vecs.push_back(mk(3'b001, 32'h00, 1, 7'b0001001, 32'hA5));
        vecs.push_back(mk(3'b001, 32'h00, 0, 7'b0011000, 32'h00));
        vecs.push_back(mk(3'b011, 32'h7E, 1, 7'b0001011, 32'h7E));
        vecs.push_back(mk(3'b100, 32'h00, 0, 7'b0011000, 32'h00));
        vecs.push_back(mk(3'b010, 32'h61, 1, 7'b0001001, 32'h61));
        vecs.push_back(mk(3'b010, 32'h62, 2, 7'b0000001, 32'h61));
        vecs.push_back(mk(3'b010, 32'h63, 3, 7'b0100001, 32'h61));
        vecs.push_back(mk(3'b111, 32'h64, 0, 7'b0011000, 32'h00));
        vecs.push_back(mk(3'b010, 32'h99, 1, 7'b0001001, 32'h99));
        vecs.push_back(mk(3'b001, 32'h00, 0, 7'b0011000, 32'h00));

        set_idle();
        #1 rst = 1'b1;
        #1;
        check_output("reset count",  32'(bus.Count),       32'd0);
        check_output("reset empty",  32'(bus.Empty),       32'd1);
        check_output("reset aempty", 32'(bus.AlmostEmpty), 32'd1);
        check_output("reset full",   32'(bus.Full),        32'd0);
        check_output("reset afull",  32'(bus.AlmostFull),  32'd0);
        check_output("reset ovf",    32'(bus.Overflow),    32'd0);
        check_output("reset unf",    32'(bus.Underflow),   32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            apply_stimulus(vecs[i].ctrl[2], vecs[i].ctrl[1], vecs[i].ctrl[0], vecs[i].data);
            check_output({tag, " count"},  32'(bus.Count),       32'(vecs[i].cnt));
            check_output({tag, " full"},   32'(bus.Full),        32'(vecs[i].flags[6]));
            check_output({tag, " afull"},  32'(bus.AlmostFull),  32'(vecs[i].flags[5]));
            check_output({tag, " empty"},  32'(bus.Empty),       32'(vecs[i].flags[4]));
            check_output({tag, " aempty"}, 32'(bus.AlmostEmpty), 32'(vecs[i].flags[3]));
            check_output({tag, " ovf"},    32'(bus.Overflow),    32'(vecs[i].flags[2]));
            check_output({tag, " unf"},    32'(bus.Underflow),   32'(vecs[i].flags[1]));
            if (vecs[i].flags[0]) check_output({tag, " head"}, bus.PopData, vecs[i].head);
        end
        set_idle();

        // Asynchronous reset between edges must drop the two stored words immediately.
        model_step("pre-rst push0", 1'b0, 1'b1, 1'b0, 32'hAA);
        model_step("pre-rst push1", 1'b0, 1'b1, 1'b0, 32'hBB);
        set_idle();
        #2 rst = 1'b1;
        #1;
        check_output("midrst count", 32'(bus.Count), 32'd0);
        check_output("midrst empty", 32'(bus.Empty), 32'd1);
        #1 rst = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(negedge clk);
        model_step("post-rst push", 1'b0, 1'b1, 1'b0, 32'hBEEF);
        check_output("post-rst head beef", bus.PopData, 32'hBEEF);

        // Ten words streamed through with overlapping push/pop so both pointers wrap twice.
        model_step("wrap flush", 1'b1, 1'b0, 1'b0, 32'h0);
        popped.delete();
        model_step("wrap0", 1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 1; i < 10; i++) model_step($sformatf("wrap%0d", i), 1'b0, 1'b1, 1'b1, 32'(i));
        model_step("wrap drain", 1'b0, 1'b0, 1'b1, 32'h0);
        check_output("wrap popped size", 32'(popped.size()), 32'd10);
        for (int i = 0; i < 10 && i < popped.size(); i++)
            check_output($sformatf("wrap order%0d", i), popped[i], 32'(i));

        for (int n = 0; n < 400; n++) begin
            f  = ($urandom_range(0, 99) < 3);
            pu = ($urandom_range(0, 99) < 60);
            po = ($urandom_range(0, 99) < 50);
            d  = $urandom;
            model_step($sformatf("rnd%0d", n), f, pu, po, d);
        end
        set_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end
endmodule
